// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - resource-shared softmax sequencer (exp, sum, invert, normalise)
// Optional output clamping and sticky sat_flag port: define SOFTMAX_SEQ_CTRL_SAT_EN.
module softmax_seq_ctrl #(
   parameter int N             = 10,
   parameter int WIDTH         = 16,
   parameter int NFRAC         = 10,
   parameter int MEM_WIDTH     = 10,
   parameter int MEM_NFRAC_EXP = 4,
   parameter int MEM_NFRAC_INV = 2,
   parameter int TABLE_WIDTH   = 18,
   parameter int TABLE_NFRAC   = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N-1:0][WIDTH-1:0]     data_in,
   output logic                        exp_rd_en,
   output logic [MEM_WIDTH-1:0]        exp_addr,
   input  logic [TABLE_WIDTH-1:0]      exp_data,
   output logic                        inv_rd_en,
   output logic [MEM_WIDTH-1:0]        inv_addr,
   input  logic [TABLE_WIDTH-1:0]      inv_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N-1:0][WIDTH-1:0]     data_out,
   output logic                        busy
`ifdef SOFTMAX_SEQ_CTRL_SAT_EN
   ,
   output logic                        sat_flag
`endif
);

   localparam int CW  = (N > 1) ? $clog2(N) : 1;
   localparam int PW  = 2 * TABLE_WIDTH;
   localparam int LSB = 2 * TABLE_NFRAC - NFRAC;
   localparam int ESH = NFRAC - MEM_NFRAC_EXP;
   localparam int ISH = TABLE_NFRAC - MEM_NFRAC_INV;
   localparam logic [PW-1:0]        INV_LIM = PW'(1) << (MEM_WIDTH - 1);
   localparam logic [MEM_WIDTH-1:0] INV_MAX = {1'b0, {(MEM_WIDTH-1){1'b1}}};
   localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_EXP, S_DRAIN, S_INV_REQ, S_INV_WAIT, S_NORM, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]              cnt;
   logic [CW-1:0]              cnt_prev;
   logic                       cnt_last;
   logic                       accept;
   logic [N-1:0][WIDTH-1:0]    data_reg;
   logic [TABLE_WIDTH-1:0]     exp_reg [N];
   logic [PW-1:0]              sum;
   logic [TABLE_WIDTH-1:0]     inv_val;

   logic signed [WIDTH-1:0]    cur_x;
   logic signed [WIDTH-1:0]    cur_shift;
   logic [MEM_WIDTH-1:0]       exp_idx;
   logic [PW-1:0]              sum_shift;
   logic [MEM_WIDTH-1:0]       inv_idx;

   logic signed [TABLE_WIDTH:0]   exp_s;
   logic signed [TABLE_WIDTH-1:0] inv_s;
   logic signed [PW:0]            prod_full;
   logic [PW-1:0]                 prod;
   logic [WIDTH-1:0]              norm_word;
   logic                          norm_ovf;

   assign accept   = in_valid & in_ready;
   assign cnt_last = (cnt == CNT_LAST);
   assign cnt_prev = cnt - CW'(1);

   // Exp-table index: arithmetic shift down to the table resolution, wrap to the address width
   assign cur_x     = data_reg[cnt];
   assign cur_shift = cur_x >>> ESH;
   assign exp_idx   = cur_shift[MEM_WIDTH-1:0];

   // Invert-table index saturates at the top of the lower half of the table
   assign sum_shift = sum >> ISH;
   assign inv_idx   = (sum_shift >= INV_LIM) ? INV_MAX : sum_shift[MEM_WIDTH-1:0];

   // Shared multiplier: exp value carries an explicit zero sign bit
   assign exp_s     = {1'b0, exp_reg[cnt]};
   assign inv_s     = inv_val;
   assign prod_full = exp_s * inv_s;
   assign prod      = prod_full[PW-1:0];
   assign norm_ovf  = |prod[PW-1:LSB+WIDTH-1];

`ifdef SOFTMAX_SEQ_CTRL_SAT_EN
   assign norm_word = norm_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : prod[LSB+WIDTH-1:LSB];
`else
   assign norm_word = prod[LSB+WIDTH-1:LSB];
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and per-state strobes
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      exp_rd_en = 1'b0;
      inv_rd_en = 1'b0;
      exp_addr  = '0;
      inv_addr  = '0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = S_EXP;
         end
         S_EXP: begin
            exp_rd_en = 1'b1;
            exp_addr  = exp_idx;
            if (cnt_last) state_nxt = S_DRAIN;
         end
         S_DRAIN:    state_nxt = S_INV_REQ;
         S_INV_REQ: begin
            inv_rd_en = 1'b1;
            inv_addr  = inv_idx;
            state_nxt = S_INV_WAIT;
         end
         S_INV_WAIT: state_nxt = S_NORM;
         S_NORM: begin
            if (cnt_last) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture, exp accumulation, inverse capture, normalisation writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         data_reg <= '0;
         sum      <= '0;
         inv_val  <= '0;
         data_out <= '0;
         for (int i = 0; i < N; i++) exp_reg[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  data_reg <= data_in;
                  sum      <= '0;
                  cnt      <= '0;
               end
            end
            S_EXP: begin
               // ROM data arriving now belongs to the element requested last cycle
               if (cnt != '0) begin
                  exp_reg[cnt_prev] <= exp_data;
                  sum               <= sum + PW'(exp_data);
               end
               cnt <= cnt_last ? '0 : cnt + CW'(1);
            end
            S_DRAIN: begin
               exp_reg[N-1] <= exp_data;
               sum          <= sum + PW'(exp_data);
            end
            S_INV_WAIT: begin
               inv_val <= inv_data;
               cnt     <= '0;
            end
            S_NORM: begin
               data_out[cnt] <= norm_word;
               cnt           <= cnt_last ? '0 : cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SOFTMAX_SEQ_CTRL_SAT_EN
   // Sticky saturation flag, cleared when a new vector is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           sat_flag <= 1'b0;
      else if (accept)                      sat_flag <= 1'b0;
      else if (state == S_NORM && norm_ovf) sat_flag <= 1'b1;
   end
`endif

endmodule
